picomips_control: RTL

- Multicycle instruction-sequencing controller for picoMIPS.
- Sits upstream of the ALU, register file and program memory.
- Owns the program counter and latches each instruction word into an instruction register.
- Decodes the opcode into the ALU function code and the datapath selects the ALU consumes.
- Paces execution with a FETCH/DECODE/EXEC FSM, a switch-wait state and a halt state.

---
 rtl/picomips_control.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/picomips_control.sv
// picoMIPS multicycle controller: owns pc/ir, decodes opcodes into ALU and
// datapath selects, and paces execution through FETCH/DECODE/EXEC/WAIT/HALT.
module picomips_control #(
  parameter int unsigned n             = 8,
  parameter int unsigned opcode_size   = 4,
  parameter int unsigned alu_code_size = 3,
  parameter int unsigned instr_w       = 24,
  parameter int unsigned pc_w          = 8
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic [instr_w-1:0]       instr,
  input  logic                     sw_go,
  output logic [pc_w-1:0]          pc,
  output logic [instr_w-1:0]       ir,
  output logic [alu_code_size-1:0] alu_func,
  output logic                     imm_sel,
  output logic                     sw_sel,
  output logic                     reg_we,
  output logic                     halted
);

  // ALU function codes shared with the ALU
  localparam logic [alu_code_size-1:0] RB    = alu_code_size'(1);
  localparam logic [alu_code_size-1:0] RADD  = alu_code_size'(2);
  localparam logic [alu_code_size-1:0] RMULT = alu_code_size'(4);

  localparam logic [opcode_size-1:0] OP_NOP   = opcode_size'(0);
  localparam logic [opcode_size-1:0] OP_ADD   = opcode_size'(1);
  localparam logic [opcode_size-1:0] OP_ADDI  = opcode_size'(2);
  localparam logic [opcode_size-1:0] OP_MULI  = opcode_size'(3);
  localparam logic [opcode_size-1:0] OP_LDSW  = opcode_size'(4);
  localparam logic [opcode_size-1:0] OP_WAITH = opcode_size'(5);
  localparam logic [opcode_size-1:0] OP_WAITL = opcode_size'(6);
  localparam logic [opcode_size-1:0] OP_JMP   = opcode_size'(7);

  // Immediate, opcode and jump-target fields must all fit in the word
  if (n + opcode_size > instr_w || pc_w + opcode_size > instr_w) begin : g_bad_params
    $error("picomips_control: instruction fields do not fit in instr_w");
  end

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WAIT, HALT} state_t;

  state_t                   state, state_n;
  logic [pc_w-1:0]          pc_n;
  logic [instr_w-1:0]       ir_n;
  logic [alu_code_size-1:0] alu_func_n;
  logic                     imm_sel_n, sw_sel_n, reg_we_n, halted_n;
  logic                     go_m, go_s;
  logic [opcode_size-1:0]   op;

  assign op = ir[instr_w-1 -: opcode_size];

  // State, datapath controls and switch synchroniser
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state    <= FETCH;
      pc       <= '0;
      ir       <= '0;
      alu_func <= RB;
      imm_sel  <= 1'b0;
      sw_sel   <= 1'b0;
      reg_we   <= 1'b0;
      halted   <= 1'b0;
      go_m     <= 1'b0;
      go_s     <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ir       <= ir_n;
      alu_func <= alu_func_n;
      imm_sel  <= imm_sel_n;
      sw_sel   <= sw_sel_n;
      reg_we   <= reg_we_n;
      halted   <= halted_n;
      go_m     <= sw_go;
      go_s     <= go_m;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ir_n       = ir;
    alu_func_n = alu_func;
    imm_sel_n  = imm_sel;
    sw_sel_n   = sw_sel;
    reg_we_n   = 1'b0;
    halted_n   = halted;
    case (state)
      FETCH: begin
        ir_n    = instr;
        state_n = DECODE;
      end
      DECODE: begin
        alu_func_n = RB;
        imm_sel_n  = 1'b0;
        sw_sel_n   = 1'b0;
        state_n    = EXEC;
        case (op)
          OP_NOP, OP_JMP: ;
          OP_ADD: begin
            alu_func_n = RADD;
            reg_we_n   = 1'b1;
          end
          OP_ADDI: begin
            alu_func_n = RADD;
            imm_sel_n  = 1'b1;
            reg_we_n   = 1'b1;
          end
          OP_MULI: begin
            alu_func_n = RMULT;
            imm_sel_n  = 1'b1;
            reg_we_n   = 1'b1;
          end
          OP_LDSW: begin
            sw_sel_n = 1'b1;
            reg_we_n = 1'b1;
          end
          OP_WAITH, OP_WAITL: state_n = WAIT;
          default: begin
            state_n  = HALT;
            halted_n = 1'b1;
          end
        endcase
      end
      EXEC: begin
        pc_n    = (op == OP_JMP) ? ir[pc_w-1:0] : pc + pc_w'(1);
        state_n = FETCH;
      end
      WAIT: begin
        // WAITH releases on a high switch, WAITL on a low one
        if ((op == OP_WAITH) ? go_s : !go_s) begin
          pc_n    = pc + pc_w'(1);
          state_n = FETCH;
        end
      end
      HALT: halted_n = 1'b1;
      default: state_n = FETCH;
    endcase
  end

endmodule
